r5p_degu_tcb_arb: RTL and testbench

- Two-requester arbiter that shares the R5P-degu single TCB system bus between the core (manager 0) and an auxiliary manager (manager 1: debug or DMA).
- The degu core multiplexes fetch, GPR read/write and load/store phases over one bus. The aux manager is therefore admitted only at instruction boundaries (core at IF phase or idle), so the core's phase sequence, and the execution log derived from it, stay coherent.
- Sits between the core's TCB port and the bus interconnect.
- Routes responses back to the owner of each transfer, accounting for the fixed TCB response delay.

---
 rtl/r5p_degu_pkg.sv | 24 ++
 rtl/r5p_degu_tcb_arb_if.sv | 18 +
 rtl/r5p_degu_tcb_arb_own.sv | 33 +++
 rtl/r5p_degu_tcb_arb.sv | 97 +++++++++
 tb/tb_r5p_degu_tcb_arb.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/r5p_degu_pkg.sv
// Shared R5P-degu definitions: core execution phase encodings and TCB arbiter state.
package r5p_degu_pkg;

  typedef enum logic [2:0] {
    PHA_IF  = 3'b000,
    PHA_MLD = 3'b001,
    PHA_MST = 3'b010,
    PHA_EXE = 3'b011,
    PHA_WB  = 3'b100,
    PHA_RS1 = 3'b101,
    PHA_RS2 = 3'b110
  } pha_t;

  typedef enum logic {
    ARB_CORE = 1'b0,
    ARB_AUX  = 1'b1
  } arb_st_t;

  // An idle core or a core about to fetch is at an instruction boundary.
  function automatic logic at_boundary(input logic vld, input logic [2:0] pha);
    return !vld || (pha == PHA_IF);
  endfunction

endpackage

// File: rtl/r5p_degu_tcb_arb_if.sv
// TCB request/response bundle; master drives the request, slave returns data and ready.
interface r5p_degu_tcb_arb_if #(
  parameter int ABW = 32,
  parameter int DBW = 32
);
  logic           vld;
  logic           wen;
  logic [ABW-1:0] adr;
  logic [1:0]     siz;
  logic           uns;
  logic [DBW-1:0] wdt;
  logic [DBW-1:0] rdt;
  logic           err;
  logic           rdy;

  modport master (output vld, wen, adr, siz, uns, wdt, input rdt, err, rdy);
  modport slave  (input vld, wen, adr, siz, uns, wdt, output rdt, err, rdy);
endinterface

// File: rtl/r5p_degu_tcb_arb_own.sv
// DLY-deep delay line of {transfer, owner} tags; reset discards all in-flight tags.
module r5p_degu_tcb_arb_own #(
  parameter int DLY = 1
)(
  input  logic clk,
  input  logic rst_n,
  input  logic trn,
  input  logic owner,
  output logic tap_trn,
  output logic tap_own
);

  logic [DLY-1:0] trn_sr;
  logic [DLY-1:0] own_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trn_sr <= '0;
      own_sr <= '0;
    end else begin
      trn_sr[0] <= trn;
      own_sr[0] <= owner;
      for (int i = 1; i < DLY; i++) begin
        trn_sr[i] <= trn_sr[i-1];
        own_sr[i] <= own_sr[i-1];
      end
    end
  end

  assign tap_trn = trn_sr[DLY-1];
  assign tap_own = own_sr[DLY-1];

endmodule

// File: rtl/r5p_degu_tcb_arb.sv
// Core/aux arbiter for the single degu TCB bus; aux is admitted only at instruction boundaries.
//   state    | meaning
//   ARB_CORE | core owns the bus; aux may be switched in combinationally at IF/idle
//   ARB_AUX  | aux owns the bus for up to MAX_BURST transfers
module r5p_degu_tcb_arb
  import r5p_degu_pkg::*;
#(
  parameter int ABW       = 32,
  parameter int DBW       = 32,
  parameter int DLY       = 1,
  parameter int MAX_BURST = 4
)(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [2:0]                c_pha,
  r5p_degu_tcb_arb_if.slave         c,
  r5p_degu_tcb_arb_if.slave         a,
  r5p_degu_tcb_arb_if.master        b,
  output logic                      own
);

  localparam int CW = $clog2(MAX_BURST + 1);

  arb_st_t        st, st_nxt;
  logic [CW-1:0]  cnt, cnt_nxt, cnt_eff;
  logic           cg, cg_nxt;
  logic           sw;
  logic           trn;
  logic           tap_trn, tap_own;
  logic [ABW-1:0] adr_mux;
  logic [DBW-1:0] wdt_mux;

  // The switch cycle already belongs to aux, so own looks ahead of the state register.
  always_comb begin
    sw      = rst_n && (st == ARB_CORE) && a.vld && !cg && at_boundary(c.vld, c_pha);
    own     = (st == ARB_AUX) || sw;
    adr_mux = own ? a.adr : c.adr;
    wdt_mux = own ? a.wdt : c.wdt;
    b.vld   = rst_n && (own ? a.vld : c.vld);
    b.wen   = own ? a.wen : c.wen;
    b.siz   = own ? a.siz : c.siz;
    b.uns   = own ? a.uns : c.uns;
    b.adr   = adr_mux;
    b.wdt   = wdt_mux;
    c.rdy   = !own && b.rdy;
    a.rdy   = own && b.rdy;
    trn     = b.vld && b.rdy;
  end

  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    cg_nxt  = cg;
    cnt_eff = (st == ARB_AUX) ? cnt : '0;
    if (own) begin
      cnt_nxt = (cnt_eff == CW'(MAX_BURST)) ? cnt_eff : cnt_eff + CW'(trn);
      if ((trn && (cnt_eff == CW'(MAX_BURST - 1))) || !a.vld) begin
        st_nxt = ARB_CORE;
        cg_nxt = 1'b1;
      end else begin
        st_nxt = ARB_AUX;
      end
    end else if (trn) begin
      cg_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= ARB_CORE;
      cnt <= '0;
      cg  <= 1'b0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
      cg  <= cg_nxt;
    end
  end

  r5p_degu_tcb_arb_own #(.DLY(DLY)) u_own (
    .clk     (clk),
    .rst_n   (rst_n),
    .trn     (trn),
    .owner   (own),
    .tap_trn (tap_trn),
    .tap_own (tap_own)
  );

  // Only a tagged response reaches a manager; idle bus data never leaks through.
  always_comb begin
    c.rdt = (tap_trn && !tap_own) ? b.rdt : '0;
    c.err = tap_trn && !tap_own && b.err;
    a.rdt = (tap_trn && tap_own) ? b.rdt : '0;
    a.err = tap_trn && tap_own && b.err;
  end

endmodule

// File: tb/tb_r5p_degu_tcb_arb.sv
// Bench for r5p_degu_tcb_arb: DLY=1 and DLY=3 instances on shared stimulus, checked against a transfer-history model.
module tb_r5p_degu_tcb_arb;
  import r5p_degu_pkg::*;

  localparam int MB   = 4;
  localparam int MAXC = 1024;
  localparam int DL0  = 1;
  localparam int DL1  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  c_pha;
  logic        c_vld, c_wen, c_uns, a_vld, a_wen, a_uns, b_rdy;
  logic [1:0]  c_siz, a_siz;
  logic [31:0] c_adr, c_wdt, a_adr, a_wdt;
  logic [31:0] brdt0, brdt1;
  logic        berr0, berr1;
  logic        own0, own1;

  r5p_degu_tcb_arb_if #(.ABW(32), .DBW(32)) ci0 ();
  r5p_degu_tcb_arb_if #(.ABW(32), .DBW(32)) ai0 ();
  r5p_degu_tcb_arb_if #(.ABW(32), .DBW(32)) bi0 ();
  r5p_degu_tcb_arb_if #(.ABW(32), .DBW(32)) ci1 ();
  r5p_degu_tcb_arb_if #(.ABW(32), .DBW(32)) ai1 ();
  r5p_degu_tcb_arb_if #(.ABW(32), .DBW(32)) bi1 ();

  assign ci0.vld = c_vld; assign ci0.wen = c_wen; assign ci0.adr = c_adr;
  assign ci0.siz = c_siz; assign ci0.uns = c_uns; assign ci0.wdt = c_wdt;
  assign ai0.vld = a_vld; assign ai0.wen = a_wen; assign ai0.adr = a_adr;
  assign ai0.siz = a_siz; assign ai0.uns = a_uns; assign ai0.wdt = a_wdt;
  assign bi0.rdy = b_rdy; assign bi0.rdt = brdt0; assign bi0.err = berr0;
  assign ci1.vld = c_vld; assign ci1.wen = c_wen; assign ci1.adr = c_adr;
  assign ci1.siz = c_siz; assign ci1.uns = c_uns; assign ci1.wdt = c_wdt;
  assign ai1.vld = a_vld; assign ai1.wen = a_wen; assign ai1.adr = a_adr;
  assign ai1.siz = a_siz; assign ai1.uns = a_uns; assign ai1.wdt = a_wdt;
  assign bi1.rdy = b_rdy; assign bi1.rdt = brdt1; assign bi1.err = berr1;

  r5p_degu_tcb_arb #(.ABW(32), .DBW(32), .DLY(DL0), .MAX_BURST(MB)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .c_pha(c_pha), .c(ci0), .a(ai0), .b(bi0), .own(own0));
  r5p_degu_tcb_arb #(.ABW(32), .DBW(32), .DLY(DL1), .MAX_BURST(MB)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .c_pha(c_pha), .c(ci1), .a(ai1), .b(bi1), .own(own1));

  logic [1:0]  o_own, o_bvld, o_crdy, o_ardy, o_cerr, o_aerr;
  logic [31:0] o_badr [2];
  logic [31:0] o_bwdt [2];
  logic [3:0]  o_bctl [2];
  logic [31:0] o_crdt [2];
  logic [31:0] o_ardt [2];
  assign o_own  = {own1, own0};
  assign o_bvld = {bi1.vld, bi0.vld};
  assign o_crdy = {ci1.rdy, ci0.rdy};
  assign o_ardy = {ai1.rdy, ai0.rdy};
  assign o_cerr = {ci1.err, ci0.err};
  assign o_aerr = {ai1.err, ai0.err};
  assign o_badr[0] = bi0.adr; assign o_badr[1] = bi1.adr;
  assign o_bwdt[0] = bi0.wdt; assign o_bwdt[1] = bi1.wdt;
  assign o_bctl[0] = {bi0.wen, bi0.siz, bi0.uns};
  assign o_bctl[1] = {bi1.wen, bi1.siz, bi1.uns};
  assign o_crdt[0] = ci0.rdt; assign o_crdt[1] = ci1.rdt;
  assign o_ardt[0] = ai0.rdt; assign o_ardt[1] = ai1.rdt;

  // Model: who owns the bus, how many aux transfers this grant, starvation guard,
  // and a per-cycle history of transfers whose responses arrive DLY cycles later.
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          m_own = 0;
  int          m_burst = 0;
  bit          m_guard = 1'b0;
  bit          h_v [MAXC];
  bit          h_o [MAXC];
  logic [31:0] h_a [MAXC];
  bit          own_h [MAXC];
  int          axfers = 0;
  logic [31:0] ardt_last [2];
  logic [2:0]  ph_tab [7];

  function automatic logic [31:0] mem_rd(input logic [31:0] adr);
    return (adr == 32'h0000_0100) ? 32'hDEAD_BEEF : {adr[15:0], ~adr[15:0]};
  endfunction

  function automatic logic mem_er(input logic [31:0] adr);
    return adr[31:28] == 4'hF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    int          dls [2];
    bit          dv  [2];
    bit          doo [2];
    logic [31:0] drd [2];
    bit          der [2];
    bit          e_own, e_bvld, e_xfer, bnd;
    int          idx;
    logic [31:0] e_adr, e_wdt;
    logic [3:0]  e_ctl;
    dls[0] = DL0;
    dls[1] = DL1;
    if (!rst_n) begin
      m_own = 0; m_burst = 0; m_guard = 1'b0;
      for (int i = 1; i <= 4; i++) if (cyc - i >= 0) h_v[cyc-i] = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      idx    = cyc - dls[k];
      dv[k]  = (idx >= 0) && h_v[idx];
      doo[k] = dv[k] ? h_o[idx] : 1'b0;
      drd[k] = dv[k] ? mem_rd(h_a[idx]) : $urandom;
      der[k] = dv[k] ? mem_er(h_a[idx]) : 1'b1;
    end
    brdt0 = drd[0]; berr0 = der[0];
    brdt1 = drd[1]; berr1 = der[1];
    bnd    = !c_vld || (c_pha == PHA_IF);
    e_own  = rst_n && ((m_own == 1) || (a_vld && bnd && !m_guard));
    e_bvld = rst_n && (e_own ? a_vld : c_vld);
    e_xfer = e_bvld && b_rdy;
    e_adr  = e_own ? a_adr : c_adr;
    e_wdt  = e_own ? a_wdt : c_wdt;
    e_ctl  = e_own ? {a_wen, a_siz, a_uns} : {c_wen, c_siz, c_uns};
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("own[%0d]", k), 32'(o_own[k]), 32'(e_own));
      chk($sformatf("b_vld[%0d]", k), 32'(o_bvld[k]), 32'(e_bvld));
      if (e_bvld) begin
        chk($sformatf("b_adr[%0d]", k), o_badr[k], e_adr);
        chk($sformatf("b_wdt[%0d]", k), o_bwdt[k], e_wdt);
        chk($sformatf("b_ctl[%0d]", k), 32'(o_bctl[k]), 32'(e_ctl));
      end
      chk($sformatf("c_rdy[%0d]", k), 32'(o_crdy[k]), 32'(!e_own && b_rdy));
      chk($sformatf("a_rdy[%0d]", k), 32'(o_ardy[k]), 32'(e_own && b_rdy));
      chk($sformatf("c_rdt[%0d]", k), o_crdt[k], (dv[k] && !doo[k]) ? drd[k] : 32'h0);
      chk($sformatf("a_rdt[%0d]", k), o_ardt[k], (dv[k] && doo[k]) ? drd[k] : 32'h0);
      chk($sformatf("c_err[%0d]", k), 32'(o_cerr[k]), 32'(dv[k] && !doo[k] && der[k]));
      chk($sformatf("a_err[%0d]", k), 32'(o_aerr[k]), 32'(dv[k] && doo[k] && der[k]));
    end
    own_h[cyc] = o_own[0];
    if (o_own[0] && o_bvld[0] && b_rdy) axfers++;
    ardt_last[0] = o_ardt[0];
    ardt_last[1] = o_ardt[1];
    @(posedge clk);
    if (e_own) begin
      if (m_own == 0) m_burst = 0;
      if (e_xfer) m_burst++;
      if ((e_xfer && m_burst == MB) || !a_vld) begin
        m_own = 0;
        m_guard = 1'b1;
      end else begin
        m_own = 1;
      end
    end else if (e_xfer) begin
      m_guard = 1'b0;
    end
    h_v[cyc] = e_xfer;
    h_o[cyc] = e_own;
    h_a[cyc] = e_adr;
    cyc++;
    #1;
  endtask

  task automatic rnd();
    c_adr = $urandom; c_wdt = $urandom; c_wen = 1'($urandom); c_siz = 2'($urandom); c_uns = 1'($urandom);
    a_adr = $urandom; a_wdt = $urandom; a_wen = 1'($urandom); a_siz = 2'($urandom); a_uns = 1'($urandom);
  endtask

  task automatic drv(input bit cv, input logic [2:0] ph, input bit av, input bit rdy);
    rnd();
    c_vld = cv; c_pha = ph; a_vld = av; b_rdy = rdy;
    step();
  endtask

  int t0;

  initial begin
    ph_tab[0] = PHA_IF;  ph_tab[1] = PHA_RS1; ph_tab[2] = PHA_RS2; ph_tab[3] = PHA_EXE;
    ph_tab[4] = PHA_MLD; ph_tab[5] = PHA_WB;  ph_tab[6] = PHA_MST;
    for (int i = 0; i < MAXC; i++) begin h_v[i] = 1'b0; h_o[i] = 1'b0; h_a[i] = '0; own_h[i] = 1'b0; end
    brdt0 = '0; brdt1 = '0; berr0 = 1'b0; berr1 = 1'b0;
    rnd();
    c_vld = 1'b0; c_pha = PHA_IF; a_vld = 1'b0; b_rdy = 1'b0;
    #1;

    // reset, with both managers requesting
    rst_n = 1'b0;
    drv(1, PHA_IF, 1, 1);
    drv(1, PHA_IF, 1, 1);
    chk("rst_own", 32'(own_h[1]), 32'd0);
    rst_n = 1'b1;

    // core-only program
    for (int i = 0; i < 14; i++) drv(1, ph_tab[i % 7], 0, (i % 5) != 4);

    // aux requests while core is in EXE, then gets the IF slot
    drv(1, PHA_EXE, 1, 0);
    drv(1, PHA_EXE, 1, 1);
    chk("exe_no_grant", 32'(own_h[cyc-1]) + 32'(own_h[cyc-2]), 32'd0);
    rnd();
    c_vld = 1'b1; c_pha = PHA_IF; a_vld = 1'b1; a_adr = 32'h0000_0100; a_wen = 1'b0; b_rdy = 1'b1;
    step();
    t0 = cyc - 1;
    chk("if_grant", 32'(own_h[t0]), 32'd1);
    drv(1, PHA_IF, 0, 1);
    chk("a_rdt_dly1", ardt_last[0], 32'hDEAD_BEEF);
    drv(1, PHA_IF, 0, 1);
    chk("core_resume", 32'(own_h[t0+2]), 32'd0);
    drv(1, PHA_IF, 0, 1);
    chk("a_rdt_dly3", ardt_last[1], 32'hDEAD_BEEF);
    drv(1, PHA_IF, 0, 1);

    // aux holds a_vld continuously against a fetching core
    t0 = cyc;
    axfers = 0;
    for (int i = 0; i < 5; i++) drv(1, PHA_IF, 1, 1);
    chk("burst_xfers", 32'(axfers), 32'd4);
    chk("guard_core", 32'(own_h[t0+4]), 32'd0);
    drv(1, PHA_IF, 1, 1);
    chk("regrant", 32'(own_h[t0+5]), 32'd1);
    drv(1, PHA_IF, 0, 1);
    drv(1, PHA_IF, 0, 1);

    // back-pressure during an aux burst
    t0 = cyc;
    axfers = 0;
    drv(0, PHA_IF, 1, 1);
    drv(0, PHA_IF, 1, 0);
    drv(0, PHA_IF, 1, 0);
    chk("hold_grant", 32'(own_h[t0+1]) + 32'(own_h[t0+2]), 32'd2);
    drv(0, PHA_IF, 1, 1);
    drv(0, PHA_IF, 1, 1);
    drv(0, PHA_IF, 1, 1);
    chk("bp_xfers", 32'(axfers), 32'd4);
    drv(0, PHA_IF, 1, 1);
    chk("guard_idle_core", 32'(own_h[t0+6]), 32'd0);
    drv(1, PHA_IF, 0, 1);

    // reset while aux owns the bus with a response in flight
    drv(0, PHA_IF, 1, 1);
    t0 = cyc;
    rst_n = 1'b0;
    drv(1, PHA_IF, 1, 1);
    chk("rst_mid_own", 32'(own_h[t0]), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) drv(1, PHA_IF, 0, 1);
    chk("post_rst_own", 32'(own_h[t0+1]), 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      drv($urandom_range(0, 3) != 0, 3'($urandom_range(0, 6)), 1'($urandom), $urandom_range(0, 3) != 0);
    end
    rst_n = 1'b1;
    drv(0, PHA_IF, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
